// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronized input, mid-bit sampling from a cycle-count bit timer,
// registered byte output with one-cycle valid and frame-error strobes.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned WORD_SIZE    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_data_DV,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] IDLE_QUAL = CNT_W'(2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [WORD_SIZE-1:0] shreg, shreg_n;
  logic [WORD_SIZE-1:0] data_n;
  logic                 dv_n, ferr_n, busy_n;
  logic                 rx_m, rx_s;

  // State, synchronizer and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= WAIT_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      o_data      <= '0;
      o_data_DV   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      rx_m        <= i_rx;
      rx_s        <= rx_m;
      o_data      <= data_n;
      o_data_DV   <= dv_n;
      o_frame_err <= ferr_n;
      o_busy      <= busy_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = o_data;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
    busy_n  = o_busy;

    case (state)
      // The synchronizer resets high and mimics an idle line for two cycles,
      // so demand three consecutive highs before trusting the line.
      WAIT_IDLE: begin
        busy_n = 1'b0;
        if (!rx_s) begin
          cnt_n = '0;
        end else if (cnt == IDLE_QUAL) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      IDLE: begin
        busy_n = 1'b0;
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[WORD_SIZE-1:1]};
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          if (rx_s) begin
            data_n  = shreg;
            dv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = WAIT_IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: drives i_rx from a bit-accurate 8N1 line model
// and compares strobes, data and timing against hand-computed values.
module tb_uart_receiver;

  localparam int unsigned CPB = 8;
  localparam int unsigned W   = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx;
  logic [W-1:0] data;
  logic         dv, ferr, busy;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .WORD_SIZE(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (data),
    .o_data_DV   (dv),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int dv_cnt = 0, ferr_cnt = 0, both_cnt = 0, long_cnt = 0, busy_cyc = 0;
  int last_dv_cyc = 0, start_cyc = 0;
  int n0, f0;
  logic         dv_q = 1'b0;
  logic [W-1:0] rxq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-low-phase
  always @(negedge clk) begin
    #1;
    if (dv) begin
      dv_cnt++;
      last_dv_cyc = cyc;
      rxq.push_back(data);
    end
    if (ferr) ferr_cnt++;
    if (dv && ferr) both_cnt++;
    if (dv && dv_q) long_cnt++;
    dv_q = dv;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [W-1:0] exp);
    if (rxq.size() == 0) check({tag, "_missing"}, 32'hDEAD, 32'(exp));
    else check(tag, 32'(rxq.pop_front()), 32'(exp));
  endtask

  // Drives one frame; must be called right after a falling edge
  task automatic send_frame(input logic [W-1:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < int'(W); i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_dv", 32'(dv), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    // 1: single frame, latency counted to the edge that captures the strobe
    n0 = dv_cnt;
    busy_cyc = 0;
    send_frame(8'hA5, 1'b1);
    check("t1_dv_count", 32'(dv_cnt - n0), 32'd1);
    check("t1_data", 32'(data), 32'hA5);
    check("t1_latency", 32'(last_dv_cyc - start_cyc + 1), 32'd79);
    check("t1_busy_cycles", 32'(busy_cyc), 32'd76);
    check("t1_busy_after", 32'(busy), 32'h0);
    expect_byte("t1_byte", 8'hA5);

    // 2: back-to-back frames
    n0 = dv_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_dv_count", 32'(dv_cnt - n0), 32'd3);
    expect_byte("t2_byte0", 8'h00);
    expect_byte("t2_byte1", 8'hFF);
    expect_byte("t2_byte2", 8'h5A);

    // 3: two-cycle low glitch on idle line
    n0 = dv_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_busy_seen", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    check("t3_busy_clear", 32'(busy), 32'h0);
    repeat (4 * CPB) @(negedge clk);
    check("t3_dv_count", 32'(dv_cnt - n0), 32'd0);
    check("t3_ferr_count", 32'(ferr_cnt - f0), 32'd0);

    // 4: bad stop bit followed by a held-low line
    n0 = dv_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("t4_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("t4_dv_count", 32'(dv_cnt - n0), 32'd0);
    check("t4_data_kept", 32'(data), 32'h5A);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t4_ferr_after_idle", 32'(ferr_cnt - f0), 32'd1);
    send_frame(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    check("t4_dv_after", 32'(dv_cnt - n0), 32'd1);
    expect_byte("t4_byte", 8'h81);

    // 5: reset in the middle of a data bit, line held low through release
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 3) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    check("t5_busy_pre", 32'(busy), 32'h1);
    n0 = dv_cnt;
    f0 = ferr_cnt;
    rst = 1'b1;
    rx  = 1'b0;
    @(negedge clk);
    check("t5_rst_data", 32'(data), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_cyc = 0;
    repeat (30) @(negedge clk);
    check("t5_low_busy", 32'(busy_cyc), 32'd0);
    check("t5_low_dv", 32'(dv_cnt - n0), 32'd0);
    check("t5_low_ferr", 32'(ferr_cnt - f0), 32'd0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_dv_after", 32'(dv_cnt - n0), 32'd1);
    expect_byte("t5_byte", 8'h77);

    // 6: continuous sweep 0x00..0xFE
    n0 = dv_cnt;
    f0 = ferr_cnt;
    for (int b = 0; b < 255; b++) send_frame(W'(b), 1'b1);
    repeat (2) @(negedge clk);
    check("t6_dv_count", 32'(dv_cnt - n0), 32'd255);
    check("t6_ferr_count", 32'(ferr_cnt - f0), 32'd0);
    for (int b = 0; b < 255; b++) expect_byte($sformatf("t6_byte_%02h", b), W'(b));

    check("dv_ferr_overlap", 32'(both_cnt), 32'd0);
    check("dv_wide_pulse", 32'(long_cnt), 32'd0);
    check("extra_bytes", 32'(rxq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
